cache_tag_store: RTL and testbench

//  Direct-mapped tag/data/state array for the L1 cache. It sits upstream of the cache controller FSM
//  and supplies the controller's lookup inputs: hit, valid_bit, dirty_bit and the cache line word.
//  It also accepts line fills from the allocate path and byte writes on CPU write hits.
//  A sequential flush engine invalidates every line on request.

---
 rtl/cache_tag_store.sv | 156 +++++++++++++++
 tb/tb_cache_tag_store.sv | 490 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cache_tag_store.sv
// cache_tag_store
//   Direct-mapped tag/data/state array for the L1 cache. Provides zero-latency lookup results
//   (hit, valid, dirty, line word, stored tag) for the cache controller, accepts whole-line fills
//   and CPU byte writes on hit, and runs a sequential sweep that invalidates every line.
//
// Ports
//   clk, rst_n          rising-edge clock, asynchronous active-low reset
//   index_i, tag_i      line select and lookup/fill tag
//   offset_i            byte lane for CPU writes
//   lookup_en_i         qualifies hit_o
//   fill_en_i           write tag, fill_data_i, valid=1, dirty=0 at index_i
//   fill_data_i         line word from memory
//   wr_en_i, wr_byte_i  CPU byte write, effective only on a hit
//   flush_req_i         start an invalidate-all sweep
//   hit_o               lookup hit (combinational)
//   valid_bit_o         valid[index] (combinational)
//   dirty_bit_o         dirty[index] (combinational)
//   cache_data_o        data[index] (combinational)
//   victim_tag_o        stored tag[index] (combinational)
//   busy_o              sweep in progress
//   flush_done_o        one-cycle pulse when the sweep completes
//   collision_o         one-cycle pulse: a write was dropped in favour of a fill

module cache_tag_store #(
    parameter int unsigned INDEX_W = 8,
    parameter int unsigned TAG_W   = 22
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [INDEX_W-1:0] index_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic [1:0]         offset_i,
    input  logic               lookup_en_i,
    input  logic               fill_en_i,
    input  logic [31:0]        fill_data_i,
    input  logic               wr_en_i,
    input  logic [7:0]         wr_byte_i,
    input  logic               flush_req_i,
    output logic               hit_o,
    output logic               valid_bit_o,
    output logic               dirty_bit_o,
    output logic [31:0]        cache_data_o,
    output logic [TAG_W-1:0]   victim_tag_o,
    output logic               busy_o,
    output logic               flush_done_o,
    output logic               collision_o
);

    localparam int unsigned Lines = 2 ** INDEX_W;

    typedef enum logic [1:0] {
        StIdle,
        StFlush,
        StDone
    } state_e;

    state_e             state_q;
    logic [INDEX_W-1:0] ctr_q;
    logic               busy_q;
    logic               flush_done_q;
    logic               collision_q;

    logic [Lines-1:0]   valid_q;
    logic [Lines-1:0]   dirty_q;
    logic [TAG_W-1:0]   tag_q  [Lines];
    logic [31:0]        data_q [Lines];

    logic tag_match;
    logic fill_ok;
    logic wr_ok;

    // Lookup ignores lookup_en_i so the write path can reuse it.
    assign tag_match = valid_q[index_i] && (tag_q[index_i] == tag_i);

    // Array updates are frozen while the sweep owns the valid/dirty bits.
    assign fill_ok = fill_en_i && !busy_q;
    assign wr_ok   = wr_en_i && !fill_en_i && tag_match && !busy_q;

    assign hit_o        = lookup_en_i && tag_match && !busy_q;
    assign valid_bit_o  = valid_q[index_i];
    assign dirty_bit_o  = dirty_q[index_i];
    assign cache_data_o = data_q[index_i];
    assign victim_tag_o = tag_q[index_i];
    assign busy_o       = busy_q;
    assign flush_done_o = flush_done_q;
    assign collision_o  = collision_q;

    // Flush sequencer: one line per cycle, then a single DONE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= StIdle;
            ctr_q        <= '0;
            busy_q       <= 1'b0;
            flush_done_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    flush_done_q <= 1'b0;
                    if (flush_req_i) begin
                        state_q <= StFlush;
                        ctr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                StFlush: begin
                    ctr_q <= ctr_q + 1'b1;
                    if (&ctr_q) begin
                        state_q      <= StDone;
                        busy_q       <= 1'b0;
                        flush_done_q <= 1'b1;
                    end
                end
                StDone: begin
                    flush_done_q <= 1'b0;
                    state_q      <= StIdle;
                end
                default: begin
                    state_q      <= StIdle;
                    busy_q       <= 1'b0;
                    flush_done_q <= 1'b0;
                end
            endcase
        end
    end

    // Line state bits are reset-defined; the sweep clears the line at ctr_q.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= '0;
            dirty_q     <= '0;
            collision_q <= 1'b0;
        end else begin
            collision_q <= fill_en_i && wr_en_i;
            if (busy_q) begin
                valid_q[ctr_q] <= 1'b0;
                dirty_q[ctr_q] <= 1'b0;
            end else if (fill_ok) begin
                valid_q[index_i] <= 1'b1;
                dirty_q[index_i] <= 1'b0;
            end else if (wr_ok) begin
                dirty_q[index_i] <= 1'b1;
            end
        end
    end

    // Tag/data storage is not reset; contents are meaningless while valid is 0.
    always_ff @(posedge clk) begin
        if (fill_ok) begin
            tag_q[index_i]  <= tag_i;
            data_q[index_i] <= fill_data_i;
        end else if (wr_ok) begin
            data_q[index_i][{offset_i, 3'b000} +: 8] <= wr_byte_i;
        end
    end

endmodule

// File: tb/tb_cache_tag_store.sv
// tb_cache_tag_store
//   Self-checking bench for cache_tag_store. A behavioural model of the line arrays and the
//   flush sweep predicts every output; inputs change on the falling edge and outputs are
//   sampled 1 time unit later.

module tb_cache_tag_store;

    localparam int Lines = 256;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [7:0]  index = '0;
    logic [21:0] tag = '0;
    logic [1:0]  offset = '0;
    logic        lookup_en = 1'b0;
    logic        fill_en = 1'b0;
    logic [31:0] fill_data = '0;
    logic        wr_en = 1'b0;
    logic [7:0]  wr_byte = '0;
    logic        flush_req = 1'b0;
    logic        hit_o;
    logic        valid_bit_o;
    logic        dirty_bit_o;
    logic [31:0] cache_data_o;
    logic [21:0] victim_tag_o;
    logic        busy_o;
    logic        flush_done_o;
    logic        collision_o;

    int errors = 0;
    int checks = 0;

    // Reference model
    bit          m_valid [Lines];
    bit          m_dirty [Lines];
    logic [21:0] m_tag   [Lines];
    logic [31:0] m_data  [Lines];
    bit          m_busy;
    bit          m_done;
    bit          m_coll;
    int          m_sweep;

    always #5 clk = ~clk;

    cache_tag_store #(
        .INDEX_W(8),
        .TAG_W  (22)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .index_i     (index),
        .tag_i       (tag),
        .offset_i    (offset),
        .lookup_en_i (lookup_en),
        .fill_en_i   (fill_en),
        .fill_data_i (fill_data),
        .wr_en_i     (wr_en),
        .wr_byte_i   (wr_byte),
        .flush_req_i (flush_req),
        .hit_o       (hit_o),
        .valid_bit_o (valid_bit_o),
        .dirty_bit_o (dirty_bit_o),
        .cache_data_o(cache_data_o),
        .victim_tag_o(victim_tag_o),
        .busy_o      (busy_o),
        .flush_done_o(flush_done_o),
        .collision_o (collision_o)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    function automatic bit m_hit();
        return lookup_en && m_valid[index] && (m_tag[index] == tag) && !m_busy;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < Lines; i++) begin
            m_valid[i] = 1'b0;
            m_dirty[i] = 1'b0;
        end
        m_busy  = 1'b0;
        m_done  = 1'b0;
        m_coll  = 1'b0;
        m_sweep = 0;
    endtask

    task automatic model_edge();
        bit old_busy;
        bit old_done;
        old_busy = m_busy;
        old_done = m_done;
        m_coll   = fill_en && wr_en;
        m_done   = 1'b0;
        if (old_busy) begin
            m_valid[m_sweep] = 1'b0;
            m_dirty[m_sweep] = 1'b0;
            m_sweep++;
            if (m_sweep == Lines) begin
                m_busy = 1'b0;
                m_done = 1'b1;
            end
        end else begin
            if (fill_en) begin
                m_tag[index]   = tag;
                m_data[index]  = fill_data;
                m_valid[index] = 1'b1;
                m_dirty[index] = 1'b0;
            end else if (wr_en && m_valid[index] && m_tag[index] == tag) begin
                m_data[index][offset*8 +: 8] = wr_byte;
                m_dirty[index] = 1'b1;
            end
            if (flush_req && !old_done) begin
                m_busy  = 1'b1;
                m_sweep = 0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        lookup_en = 1'b0;
        fill_en   = 1'b0;
        wr_en     = 1'b0;
        flush_req = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        rst_n = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks += 3;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy got=%0b exp=0", busy_o); end
        if (flush_done_o !== 1'b0) begin
            errors++; $display("FAIL reset_flush_done got=%0b exp=0", flush_done_o);
        end
        if (collision_o !== 1'b0) begin
            errors++; $display("FAIL reset_collision got=%0b exp=0", collision_o);
        end
        lookup_en = 1'b1;
        for (int i = 0; i < Lines; i++) begin
            index = 8'(i);
            tag   = 22'($urandom);
            #1;
            checks += 3;
            if (hit_o !== 1'b0) begin
                errors++; $display("FAIL reset_hit idx=%0d got=%0b exp=0", i, hit_o);
            end
            if (valid_bit_o !== 1'b0) begin
                errors++; $display("FAIL reset_valid idx=%0d got=%0b exp=0", i, valid_bit_o);
            end
            if (dirty_bit_o !== 1'b0) begin
                errors++; $display("FAIL reset_dirty idx=%0d got=%0b exp=0", i, dirty_bit_o);
            end
        end
        lookup_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_fill_hit();
        index     = 8'h05;
        tag       = 22'h12345;
        fill_data = 32'hAABBCCDD;
        fill_en   = 1'b1;
        tick();
        fill_en   = 1'b0;
        lookup_en = 1'b1;
        #1;
        checks += 3;
        if (hit_o !== 1'b1) begin errors++; $display("FAIL fill_hit got=%0b exp=1", hit_o); end
        if (cache_data_o !== 32'hAABBCCDD) begin
            errors++; $display("FAIL fill_data got=%h exp=aabbccdd", cache_data_o);
        end
        if (dirty_bit_o !== 1'b0) begin
            errors++; $display("FAIL fill_dirty got=%0b exp=0", dirty_bit_o);
        end
        @(negedge clk);
    endtask

    task automatic test_byte_write();
        index   = 8'h05;
        tag     = 22'h12345;
        offset  = 2'd2;
        wr_byte = 8'h55;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        #1;
        checks += 2;
        if (cache_data_o !== 32'hAA55CCDD) begin
            errors++; $display("FAIL bytewr_data got=%h exp=aa55ccdd", cache_data_o);
        end
        if (dirty_bit_o !== 1'b1) begin
            errors++; $display("FAIL bytewr_dirty got=%0b exp=1", dirty_bit_o);
        end
        tag = 22'h00001;
        #1;
        checks += 4;
        if (hit_o !== 1'b0) begin errors++; $display("FAIL miss_hit got=%0b exp=0", hit_o); end
        if (valid_bit_o !== 1'b1) begin
            errors++; $display("FAIL miss_valid got=%0b exp=1", valid_bit_o);
        end
        if (dirty_bit_o !== 1'b1) begin
            errors++; $display("FAIL miss_dirty got=%0b exp=1", dirty_bit_o);
        end
        if (victim_tag_o !== 22'h12345) begin
            errors++; $display("FAIL victim_tag got=%h exp=12345", victim_tag_o);
        end
        lookup_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_write_miss_collision();
        index   = 8'h06;
        tag     = 22'h0ABCD;
        offset  = 2'd1;
        wr_byte = 8'h99;
        wr_en   = 1'b1;
        tick();
        wr_en = 1'b0;
        #1;
        checks += 2;
        if (valid_bit_o !== 1'b0) begin
            errors++; $display("FAIL wrmiss_valid got=%0b exp=0", valid_bit_o);
        end
        if (dirty_bit_o !== 1'b0) begin
            errors++; $display("FAIL wrmiss_dirty got=%0b exp=0", dirty_bit_o);
        end
        @(negedge clk);
        index     = 8'h07;
        tag       = 22'h00003;
        fill_data = 32'h11223344;
        offset    = 2'd0;
        wr_byte   = 8'hEE;
        fill_en   = 1'b1;
        wr_en     = 1'b1;
        tick();
        fill_en = 1'b0;
        wr_en   = 1'b0;
        #1;
        checks += 4;
        if (collision_o !== 1'b1) begin
            errors++; $display("FAIL collision_pulse got=%0b exp=1", collision_o);
        end
        if (cache_data_o !== 32'h11223344) begin
            errors++; $display("FAIL collision_data got=%h exp=11223344", cache_data_o);
        end
        if (valid_bit_o !== 1'b1) begin
            errors++; $display("FAIL collision_valid got=%0b exp=1", valid_bit_o);
        end
        if (dirty_bit_o !== 1'b0) begin
            errors++; $display("FAIL collision_dirty got=%0b exp=0", dirty_bit_o);
        end
        tick();
        #1;
        checks++;
        if (collision_o !== 1'b0) begin
            errors++; $display("FAIL collision_width got=%0b exp=0", collision_o);
        end
        @(negedge clk);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            index     = 8'($urandom_range(0, 7));
            tag       = 22'($urandom_range(0, 3));
            offset    = 2'($urandom);
            wr_byte   = 8'($urandom);
            fill_data = $urandom;
            lookup_en = ($urandom_range(0, 3) != 0);
            fill_en   = ($urandom_range(0, 3) == 0);
            wr_en     = ($urandom_range(0, 4) < 2);
            #1;
            checks += 5;
            if (hit_o !== m_hit()) begin
                errors++; $display("FAIL rand_hit n=%0d got=%0b exp=%0b", n, hit_o, m_hit());
            end
            if (valid_bit_o !== m_valid[index]) begin
                errors++;
                $display("FAIL rand_valid n=%0d got=%0b exp=%0b", n, valid_bit_o, m_valid[index]);
            end
            if (dirty_bit_o !== m_dirty[index]) begin
                errors++;
                $display("FAIL rand_dirty n=%0d got=%0b exp=%0b", n, dirty_bit_o, m_dirty[index]);
            end
            if (collision_o !== m_coll) begin
                errors++;
                $display("FAIL rand_collision n=%0d got=%0b exp=%0b", n, collision_o, m_coll);
            end
            if (busy_o !== 1'b0) begin
                errors++; $display("FAIL rand_busy n=%0d got=%0b exp=0", n, busy_o);
            end
            if (m_valid[index]) begin
                checks += 2;
                if (cache_data_o !== m_data[index]) begin
                    errors++;
                    $display("FAIL rand_data n=%0d got=%h exp=%h", n, cache_data_o, m_data[index]);
                end
                if (victim_tag_o !== m_tag[index]) begin
                    errors++;
                    $display("FAIL rand_tag n=%0d got=%h exp=%h", n, victim_tag_o, m_tag[index]);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_flush();
        int  busy_cnt;
        int  done_cnt;
        int  post;
        bit  finished;
        logic [7:0] idx_list [3];
        idx_list[0] = 8'h00;
        idx_list[1] = 8'h80;
        idx_list[2] = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            index     = idx_list[k];
            tag       = 22'(32'h2000 + k);
            fill_data = $urandom;
            fill_en   = 1'b1;
            tick();
        end
        fill_en   = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        busy_cnt  = 0;
        done_cnt  = 0;
        post      = 0;
        finished  = 1'b0;
        lookup_en = 1'b1;
        index     = 8'h80;
        tag       = 22'h2001;
        for (int cyc = 0; cyc < 400 && !finished; cyc++) begin
            #1;
            if (busy_o) busy_cnt++;
            if (flush_done_o) done_cnt++;
            checks += 4;
            if (busy_o !== m_busy) begin
                errors++; $display("FAIL flush_busy cyc=%0d got=%0b exp=%0b", cyc, busy_o, m_busy);
            end
            if (flush_done_o !== m_done) begin
                errors++;
                $display("FAIL flush_done cyc=%0d got=%0b exp=%0b", cyc, flush_done_o, m_done);
            end
            if (hit_o !== m_hit()) begin
                errors++; $display("FAIL flush_hit cyc=%0d got=%0b exp=%0b", cyc, hit_o, m_hit());
            end
            if (collision_o !== m_coll) begin
                errors++;
                $display("FAIL flush_collision cyc=%0d got=%0b exp=%0b", cyc, collision_o, m_coll);
            end
            if (done_cnt > 0 && !busy_o) begin
                post++;
                if (post > 3) finished = 1'b1;
            end
            flush_req = (busy_o && busy_cnt == 50);
            fill_en   = (busy_o && busy_cnt == 60);
            wr_en     = fill_en;
            fill_data = 32'hDEADBEEF;
            tick();
        end
        idle_inputs();
        checks += 2;
        if (busy_cnt !== 256) begin
            errors++; $display("FAIL flush_busy_cycles got=%0d exp=256", busy_cnt);
        end
        if (done_cnt !== 1) begin
            errors++; $display("FAIL flush_done_pulses got=%0d exp=1", done_cnt);
        end
        lookup_en = 1'b1;
        for (int k = 0; k < 3; k++) begin
            index = idx_list[k];
            tag   = 22'(32'h2000 + k);
            #1;
            checks += 2;
            if (valid_bit_o !== 1'b0) begin
                errors++; $display("FAIL post_flush_valid idx=%h got=%0b exp=0", index, valid_bit_o);
            end
            if (hit_o !== 1'b0) begin
                errors++; $display("FAIL post_flush_hit idx=%h got=%0b exp=0", index, hit_o);
            end
        end
        lookup_en = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_mid_flush();
        int busy_cnt;
        int done_cnt;
        index     = 8'h10;
        tag       = 22'h3C3C3;
        fill_data = 32'h5A5A5A5A;
        fill_en   = 1'b1;
        tick();
        fill_en   = 1'b0;
        flush_req = 1'b1;
        tick();
        flush_req = 1'b0;
        busy_cnt  = 0;
        for (int cyc = 0; cyc < 200 && busy_cnt < 100; cyc++) begin
            #1;
            if (busy_o) busy_cnt++;
            if (busy_cnt < 100) tick();
        end
        checks++;
        if (busy_cnt !== 100) begin
            errors++; $display("FAIL midrst_reach_100 got=%0d exp=100", busy_cnt);
        end
        rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (busy_o !== 1'b0) begin
            errors++; $display("FAIL midrst_busy got=%0b exp=0", busy_o);
        end
        done_cnt = 0;
        repeat (2) begin
            @(negedge clk);
            if (flush_done_o) done_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 300; c++) begin
            #1;
            if (flush_done_o) done_cnt++;
            tick();
        end
        checks++;
        if (done_cnt !== 0) begin
            errors++; $display("FAIL midrst_no_done got=%0d exp=0", done_cnt);
        end
        for (int i = 0; i < Lines; i++) begin
            index = 8'(i);
            #1;
            checks++;
            if (valid_bit_o !== 1'b0) begin
                errors++; $display("FAIL midrst_valid idx=%0d got=%0b exp=0", i, valid_bit_o);
            end
        end
        @(negedge clk);
        index     = 8'h33;
        tag       = 22'h0ABCDE;
        fill_data = 32'hCAFEF00D;
        fill_en   = 1'b1;
        tick();
        fill_en   = 1'b0;
        lookup_en = 1'b1;
        #1;
        checks += 2;
        if (hit_o !== 1'b1) begin
            errors++; $display("FAIL midrst_refill_hit got=%0b exp=1", hit_o);
        end
        if (cache_data_o !== 32'hCAFEF00D) begin
            errors++; $display("FAIL midrst_refill_data got=%h exp=cafef00d", cache_data_o);
        end
        lookup_en = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        model_reset();
        test_reset();
        test_fill_hit();
        test_byte_write();
        test_write_miss_collision();
        test_random();
        test_flush();
        test_reset_mid_flush();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
